// File: rtl/spi_accel_responder.sv
// -----------------------------------------------------------------------------
// spi_accel_responder
//   SPI slave (CPOL=1, CPHA=1, MSB first) that answers the 3-axis
//   accelerometer register protocol so the host-side read path can be
//   exercised without the physical sensor. Axis samples come in on ports and
//   are snapshotted at chip-select fall, so a multi-byte read is coherent.
//
//   Command byte: bit7 = R/W (1 = read), bit6 = MB (auto-increment),
//                 bits5:0 = register address.
//   Register map: 0x00 DEVID (RO), 0x2D POWER_CTL (RW), 0x30 INT_SOURCE (RO),
//                 0x31 DATA_FORMAT (RW), 0x32..0x37 shadow X/Y/Z, LSB first.
//                 Every other address reads 0x00 and ignores writes.
//
//   Optional build macro: RESPONDER_DATA_READY_EN
//     defined   : sample_valid sets a DATA_READY flag (0x30 bit7, drives int1),
//                 cleared when a read byte from 0x32 completes; set wins.
//     undefined : 0x30 reads 0x00 and int1 is tied low.
//
// Ports
//   MAX10_CLK1_50        system clock
//   rst                  asynchronous active-high reset
//   sclk, cs_n, sdi      SPI inputs from the master (asynchronous to clk)
//   sdo, sdo_oe          SPI data out and its output enable
//   x_in, y_in, z_in     axis samples (two's complement)
//   sample_valid         one-cycle pulse: new x/y/z presented
//   power_ctl            register 0x2D
//   data_format          register 0x31
//   measure              power_ctl[3]
//   wr_strobe            one-cycle pulse per committed register write
//   wr_addr, wr_data     address/data of the last committed write
//   txn_done             one-cycle pulse on cs_n rise after a full command byte
//   int1                 DATA_READY interrupt (optional feature)
// -----------------------------------------------------------------------------
module spi_accel_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hE5
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        measure,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        txn_done,
  output logic        int1
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s, w_cs_s, w_sdi_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      // NOTE: cs_n is reset to its asserted level so that a chip select held
      // low across reset is not mistaken for a fresh falling edge; only a
      // genuine high-then-low sequence starts a transaction. sclk resets to
      // its idle-high level for the same reason.
      r_sclk_sync <= '1;
      r_cs_sync   <= '0;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b1;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_d;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_cmd_sr;      // first seven command bits; the eighth is sdi
  logic [6:0]  r_data_sr;     // first seven data bits; the eighth is sdi
  logic [7:0]  r_out_sr;
  logic        r_rw;
  logic        r_mb;
  logic [5:0]  r_addr;
  logic        r_first_done;  // single-byte mode: first data byte consumed
  logic [15:0] r_x, r_y, r_z;
  logic [7:0]  r_power_ctl;
  logic [7:0]  r_data_format;
  logic        r_sdo;
  logic        r_sdo_oe;
  logic        r_wr_strobe;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_txn_done;
`ifdef RESPONDER_DATA_READY_EN
  logic        r_dr_flag;
`else
  logic        w_unused_sample_valid;
  assign w_unused_sample_valid = sample_valid;
`endif

  logic [5:0] w_cmd_addr;
  logic [7:0] w_data_byte;
  logic       w_active;

  assign w_cmd_addr  = {r_cmd_sr[4:0], w_sdi_s};
  assign w_data_byte = {r_data_sr, w_sdi_s};
  // In single-byte mode only the first data byte is acted on.
  assign w_active    = r_mb | ~r_first_done;

  // Register read mux.
  function automatic logic [7:0] f_reg_read(input logic [5:0] addr);
    // NOTE: the default arm assigns every path, so this stays pure
    // combinational logic with no inferred storage.
    case (addr)
      ADDR_DEVID:       f_reg_read = DEVID;
      ADDR_POWER_CTL:   f_reg_read = r_power_ctl;
`ifdef RESPONDER_DATA_READY_EN
      ADDR_INT_SOURCE:  f_reg_read = {r_dr_flag, 7'b0};
`endif
      ADDR_DATA_FORMAT: f_reg_read = r_data_format;
      6'h32:            f_reg_read = r_x[7:0];
      6'h33:            f_reg_read = r_x[15:8];
      6'h34:            f_reg_read = r_y[7:0];
      6'h35:            f_reg_read = r_y[15:8];
      6'h36:            f_reg_read = r_z[7:0];
      6'h37:            f_reg_read = r_z[15:8];
      default:          f_reg_read = 8'h00;
    endcase
  endfunction

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_cmd_sr      <= '0;
      r_data_sr     <= '0;
      r_out_sr      <= '0;
      r_rw          <= 1'b0;
      r_mb          <= 1'b0;
      r_addr        <= '0;
      r_first_done  <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_z           <= '0;
      r_power_ctl   <= '0;
      r_data_format <= '0;
      r_sdo         <= 1'b0;
      r_sdo_oe      <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_txn_done    <= 1'b0;
`ifdef RESPONDER_DATA_READY_EN
      r_dr_flag     <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only in
      // the cycle of the event; all state updates here are non-blocking so
      // every branch sees the values from the start of the cycle.
      r_wr_strobe <= 1'b0;
      r_txn_done  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_x       <= x_in;
            r_y       <= y_in;
            r_z       <= z_in;
            r_bit_cnt <= '0;
            r_sdo     <= 1'b0;
            r_sdo_oe  <= 1'b1;
            r_state   <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (w_cs_rise) begin
            // Command byte incomplete: abort silently, no txn_done.
            r_sdo    <= 1'b0;
            r_sdo_oe <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_sclk_rise) begin
            r_cmd_sr  <= {r_cmd_sr[5:0], w_sdi_s};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_rw         <= r_cmd_sr[6];
              r_mb         <= r_cmd_sr[5];
              r_addr       <= w_cmd_addr;
              r_first_done <= 1'b0;
              r_out_sr     <= r_cmd_sr[6] ? f_reg_read(w_cmd_addr) : 8'h00;
              r_state      <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_cs_rise) begin
            // Any partial data byte is dropped here without being committed.
            r_sdo      <= 1'b0;
            r_sdo_oe   <= 1'b0;
            r_txn_done <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (w_sclk_fall) begin
            r_sdo    <= r_out_sr[7];
            r_out_sr <= {r_out_sr[6:0], 1'b0};
          end else if (w_sclk_rise) begin
            r_data_sr <= {r_data_sr[5:0], w_sdi_s};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_active && !r_rw &&
                  (r_addr == ADDR_POWER_CTL || r_addr == ADDR_DATA_FORMAT)) begin
                if (r_addr == ADDR_POWER_CTL) r_power_ctl   <= w_data_byte;
                else                          r_data_format <= w_data_byte;
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr;
                r_wr_data   <= w_data_byte;
              end
`ifdef RESPONDER_DATA_READY_EN
              if (w_active && r_rw && r_addr == ADDR_DATAX0) r_dr_flag <= 1'b0;
`endif
              if (r_mb) begin
                // 6-bit address wraps 0x3F -> 0x00 naturally.
                r_addr   <= r_addr + 6'd1;
                r_out_sr <= r_rw ? f_reg_read(r_addr + 6'd1) : 8'h00;
              end else begin
                r_first_done <= 1'b1;
                r_out_sr     <= 8'h00;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase

`ifdef RESPONDER_DATA_READY_EN
      // Placed last so a new sample wins over a same-cycle clear.
      if (sample_valid) r_dr_flag <= 1'b1;
`endif
    end
  end

  assign sdo         = r_sdo;
  assign sdo_oe      = r_sdo_oe;
  assign power_ctl   = r_power_ctl;
  assign data_format = r_data_format;
  assign measure     = r_power_ctl[3];
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign txn_done    = r_txn_done;
`ifdef RESPONDER_DATA_READY_EN
  assign int1        = r_dr_flag;
`else
  assign int1        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_accel_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_accel_responder
//   Self-checking bench: an SPI master model drives transactions, and a
//   byte-level register model predicts sdo bytes, register contents, write
//   strobes and txn_done counts. Honours RESPONDER_DATA_READY_EN if defined.
// -----------------------------------------------------------------------------
module tb_spi_accel_responder;

  localparam int HALF = 5;  // clk cycles per sclk half period (sclk = clk/10)

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, cs_n, sdi;
  logic        sdo, sdo_oe;
  logic [15:0] x_in, y_in, z_in;
  logic        sample_valid;
  logic [7:0]  power_ctl, data_format;
  logic        measure, wr_strobe, txn_done, int1;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  always #10 clk = ~clk;

  spi_accel_responder dut (
    .MAX10_CLK1_50(clk),
    .rst          (rst),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .sdi          (sdi),
    .sdo          (sdo),
    .sdo_oe       (sdo_oe),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .data_format  (data_format),
    .measure      (measure),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .txn_done     (txn_done),
    .int1         (int1)
  );

  int total = 0;
  int bad   = 0;

  // Pulse monitors (only these blocks write the counters).
  int wr_cnt  = 0;
  int txn_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (txn_done)  txn_cnt++;
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_power = 8'h00;
  logic [7:0]  m_format = 8'h00;
  logic        m_flag = 1'b0;
  logic [15:0] m_x = '0, m_y = '0, m_z = '0;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          exp_wr, exp_txn;
  logic [5:0]  exp_waddr;
  logic [7:0]  exp_wdata;

  function automatic logic [7:0] m_read(input logic [5:0] a);
    case (a)
      6'h00:   return 8'hE5;
      6'h2D:   return m_power;
      6'h30:   return {m_flag, 7'b0};
      6'h31:   return m_format;
      6'h32:   return m_x[7:0];
      6'h33:   return m_x[15:8];
      6'h34:   return m_y[7:0];
      6'h35:   return m_y[15:8];
      6'h36:   return m_z[7:0];
      6'h37:   return m_z[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // Predicts one transaction of nbits sclk cycles from tx_q.
  task automatic model_txn(input int nbits);
    logic [7:0] cmd;
    logic [5:0] a;
    bit         act;
    cmd = tx_q[0];
    a   = cmd[5:0];
    m_x = x_in; m_y = y_in; m_z = z_in;
    exp_q = {};
    exp_q.push_back(8'h00);  // sdo is 0 during the command byte
    exp_wr  = 0;
    exp_txn = (nbits >= 8) ? 1 : 0;
    for (int k = 1; k < nbits / 8; k++) begin
      act = cmd[6] || (k == 1);
      if (cmd[7]) begin
        exp_q.push_back(act ? m_read(a) : 8'h00);
        if (act && a == 6'h32) m_flag = 1'b0;
      end else begin
        exp_q.push_back(8'h00);
        if (act && (a == 6'h2D || a == 6'h31)) begin
          if (a == 6'h2D) m_power = tx_q[k];
          else            m_format = tx_q[k];
          exp_wr++;
          exp_waddr = a;
          exp_wdata = tx_q[k];
        end
      end
      if (cmd[6]) a = a + 6'd1;
    end
  endtask

  task automatic model_reset();
    m_power = 8'h00; m_format = 8'h00; m_flag = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI master, mode 3: sdi changes on falling sclk, sdo sampled before rising.
  task automatic spi_frame(input int nbits);
    logic [7:0] b;
    logic [7:0] cur;
    cur  = 8'h00;
    rx_q = {};
    @(negedge clk);
    cs_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < nbits; i++) begin
      b    = tx_q[i / 8];
      sclk = 1'b0;
      sdi  = b[7 - (i % 8)];
      wait_clks(HALF);
      cur  = {cur[6:0], sdo};
      sclk = 1'b1;
      wait_clks(HALF);
      if (i % 8 == 7) rx_q.push_back(cur);
    end
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic run_txn(input int nbits);
    model_txn(nbits);
    spi_frame(nbits);
  endtask

  task automatic pulse_sample();
    @(negedge clk);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
`ifdef RESPONDER_DATA_READY_EN
    m_flag = 1'b1;
`endif
    wait_clks(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [35:0] obs;
    rst = 1'b1; sclk = 1'b1; cs_n = 1'b1; sdi = 1'b0; sample_valid = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    wait_clks(5);
    obs = {sdo, sdo_oe, power_ctl, data_format, measure, wr_strobe,
           wr_addr, wr_data, txn_done, int1};
    total++;
    if (obs !== 36'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    @(negedge clk); rst = 1'b0;
    wait_clks(5);
    total++;
    if (sdo_oe !== 1'b0 || txn_cnt != 0) begin
      bad++; $display("FAIL reset_release: sdo_oe=%b txn=%0d want 0/0", sdo_oe, txn_cnt);
    end
  endtask

  task automatic test_read_devid();
    int t0;
    t0   = txn_cnt;
    tx_q = {8'h80, 8'h00};
    run_txn(16);
    total++;
    if (rx_q[1] !== exp_q[1] || exp_q[1] !== 8'hE5) begin
      bad++; $display("FAIL devid: got %h want %h", rx_q[1], exp_q[1]);
    end
    total++;
    if (txn_cnt - t0 != 1) begin
      bad++; $display("FAIL devid_txn_done: got %0d pulses want 1", txn_cnt - t0);
    end
  endtask

  task automatic test_write_power();
    int w0;
    w0   = wr_cnt;
    tx_q = {8'h2D, 8'h08};
    run_txn(16);
    total++;
    if (power_ctl !== m_power || measure !== m_power[3]) begin
      bad++; $display("FAIL power_ctl: got %h/%b want %h/%b", power_ctl, measure, m_power, m_power[3]);
    end
    total++;
    if (wr_cnt - w0 != exp_wr || wr_addr !== exp_waddr || wr_data !== exp_wdata) begin
      bad++; $display("FAIL power_wr: got n=%0d %h %h want n=%0d %h %h",
                      wr_cnt - w0, wr_addr, wr_data, exp_wr, exp_waddr, exp_wdata);
    end
  endtask

  task automatic test_burst_snapshot();
    x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h00FF;
    tx_q = {8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(56);
    for (int k = 0; k < 7; k++) begin
      total++;
      if (rx_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL burst byte%0d: got %h want %h", k, rx_q[k], exp_q[k]);
      end
    end
    // Input changes after the command byte must not affect this burst.
    model_txn(56);
    fork
      spi_frame(56);
      begin
        wait_clks(5 + 2 * HALF * 9);
        x_in = 16'h5678;
      end
    join
    for (int k = 1; k < 3; k++) begin
      total++;
      if (rx_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL snapshot byte%0d: got %h want %h", k, rx_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_abort();
    int w0, t0;
    w0   = wr_cnt; t0 = txn_cnt;
    tx_q = {8'h31, 8'hA5};
    run_txn(12);
    total++;
    if (data_format !== m_format || wr_cnt != w0) begin
      bad++; $display("FAIL abort_data: got fmt=%h wr=%0d want %h 0", data_format, wr_cnt - w0, m_format);
    end
    total++;
    if (txn_cnt - t0 != exp_txn) begin
      bad++; $display("FAIL abort_txn_done: got %0d want %0d", txn_cnt - t0, exp_txn);
    end
    // Abort inside the command byte: no txn_done.
    t0   = txn_cnt;
    tx_q = {8'h80};
    run_txn(4);
    total++;
    if (txn_cnt - t0 != exp_txn) begin
      bad++; $display("FAIL cmd_abort_txn_done: got %0d want %0d", txn_cnt - t0, exp_txn);
    end
  endtask

  task automatic test_wrap_readonly();
    int w0;
    tx_q = {8'hFF, 8'h00, 8'h00};
    run_txn(24);
    for (int k = 1; k < 3; k++) begin
      total++;
      if (rx_q[k] !== exp_q[k]) begin
        bad++; $display("FAIL wrap byte%0d: got %h want %h", k, rx_q[k], exp_q[k]);
      end
    end
    w0   = wr_cnt;
    tx_q = {8'h00, 8'h55};
    run_txn(16);
    total++;
    if (wr_cnt != w0) begin
      bad++; $display("FAIL ro_write_strobe: got %0d want 0", wr_cnt - w0);
    end
    tx_q = {8'h80, 8'h00};
    run_txn(16);
    total++;
    if (rx_q[1] !== exp_q[1]) begin
      bad++; $display("FAIL ro_devid: got %h want %h", rx_q[1], exp_q[1]);
    end
  endtask

  task automatic test_data_ready();
    pulse_sample();
    total++;
    if (int1 !== m_flag) begin
      bad++; $display("FAIL int1_set: got %b want %b", int1, m_flag);
    end
    tx_q = {8'hB0, 8'h00};
    run_txn(16);
    total++;
    if (rx_q[1] !== exp_q[1]) begin
      bad++; $display("FAIL int_source: got %h want %h", rx_q[1], exp_q[1]);
    end
    tx_q = {8'hF2, 8'h00, 8'h00};
    run_txn(24);
    total++;
    if (int1 !== m_flag) begin
      bad++; $display("FAIL int1_clear: got %b want %b", int1, m_flag);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [35:0] obs;
    int          t0;
    tx_q = {8'h2D, 8'h0C};
    run_txn(16);
    pulse_sample();
    t0   = txn_cnt;
    tx_q = {8'hF2, 8'h00, 8'h00, 8'h00, 8'h00};
    fork
      spi_frame(40);
      begin
        wait_clks(5 + 2 * HALF * 12);
        total++;
        if (sdo_oe !== 1'b1) begin
          bad++; $display("FAIL mid_burst_oe: got %b want 1", sdo_oe);
        end
        rst = 1'b1;
        #1;
        obs = {sdo, sdo_oe, power_ctl, data_format, measure, wr_strobe,
               wr_addr, wr_data, txn_done, int1};
        total++;
        if (obs !== 36'h0) begin
          bad++; $display("FAIL mid_burst_reset: got %h want 0", obs);
        end
        wait_clks(3);
        rst = 1'b0;
      end
    join
    model_reset();
    total++;
    if (txn_cnt != t0 || sdo_oe !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: txn=%0d oe=%b want 0/0", txn_cnt - t0, sdo_oe);
    end
    tx_q = {8'h80, 8'h00};
    run_txn(16);
    total++;
    if (rx_q[1] !== exp_q[1]) begin
      bad++; $display("FAIL post_reset_devid: got %h want %h", rx_q[1], exp_q[1]);
    end
  endtask

  task automatic test_random();
    logic [5:0] addrs[11];
    logic [7:0] cmd;
    int nbytes, nbits, w0, t0;
    addrs = '{6'h00, 6'h2D, 6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h36, 6'h37, 6'h3F};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) pulse_sample();
      x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
      cmd[7]   = 1'($urandom);
      cmd[6]   = 1'($urandom);
      cmd[5:0] = ($urandom_range(4, 0) == 0) ? 6'($urandom) : addrs[$urandom_range(10, 0)];
      nbytes   = $urandom_range(4, 1);
      nbits    = 8 * (nbytes + 1);
      if ($urandom_range(4, 0) == 0) nbits = nbits - $urandom_range(7, 1);
      tx_q = {cmd};
      for (int k = 0; k < nbytes; k++) tx_q.push_back(8'($urandom));
      w0 = wr_cnt; t0 = txn_cnt;
      run_txn(nbits);
      for (int k = 0; k < exp_q.size(); k++) begin
        if (cmd[7] || k == 0) begin
          total++;
          if (rx_q[k] !== exp_q[k]) begin
            bad++; $display("FAIL rand%0d cmd=%h byte%0d: got %h want %h", n, cmd, k, rx_q[k], exp_q[k]);
          end
        end
      end
      total++;
      if (power_ctl !== m_power || data_format !== m_format || int1 !== m_flag) begin
        bad++; $display("FAIL rand%0d regs: got %h %h %b want %h %h %b", n,
                        power_ctl, data_format, int1, m_power, m_format, m_flag);
      end
      total++;
      if (wr_cnt - w0 != exp_wr || txn_cnt - t0 != exp_txn) begin
        bad++; $display("FAIL rand%0d pulses: got wr=%0d txn=%0d want %0d %0d", n,
                        wr_cnt - w0, txn_cnt - t0, exp_wr, exp_txn);
      end
      if (exp_wr > 0) begin
        total++;
        if (wr_addr !== exp_waddr || wr_data !== exp_wdata) begin
          bad++; $display("FAIL rand%0d wr_last: got %h %h want %h %h", n,
                          wr_addr, wr_data, exp_waddr, exp_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_devid();
    test_write_power();
    test_burst_snapshot();
    test_abort();
    test_wrap_readonly();
    test_data_ready();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
Synthesizable SPI slave that emulates the on-board 3-axis accelerometer's 4-wire SPI register interface. It answers the same command/address/data framing the accelerometer master issues, so the sensor read path, pitch/roll maths and the SPI master can be exercised on hardware without the real sensor. Axis data comes from input ports, for example from a stimulus ROM, a UART loader or a counter. Register writes are exposed as status outputs.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the sclk/cs_n/sdi synchronizers (minimum 2)
DEVID, 8'hE5, value returned at register 0x00

Ports:
MAX10_CLK1_50  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master; idles high (CPOL=1, CPHA=1)
cs_n  input  1  SPI chip select, active low
sdi  input  1  master-to-slave data, MSB first
sdo  output  1  slave-to-master data, MSB first
sdo_oe  output  1  high while cs_n is low (synchronized)
x_in, y_in, z_in  input  16 each  axis samples, two's complement
sample_valid  input  1  one-cycle pulse: new x/y/z presented
power_ctl  output  8  register 0x2D contents
data_format  output  8  register 0x31 contents
measure  output  1  power_ctl[3]
wr_strobe  output  1  one-cycle pulse per committed register write
wr_addr  output  6  address of the last committed write
wr_data  output  8  data of the last committed write
txn_done  output  1  one-cycle pulse on cs_n rise after a full command byte
int1  output  1  see Optional Feature

Behaviour:
- Reset: all outputs are 0. power_ctl and data_format are 0x00. The FSM is in IDLE and the shadow registers are 0.
- sclk, cs_n and sdi pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized sclk. Supported sclk is at most MAX10_CLK1_50/8.
- Sampling: sdi is sampled on the synchronized sclk rising edge. sdo is updated on the synchronized sclk falling edge, no later than SYNC_STAGES+2 clocks after the pin edge.
- FSM states: IDLE, CMD, DATA.
- IDLE to CMD: on cs_n falling. At this point:
  - x_in/y_in/z_in are snapshotted into shadow registers, so a burst is coherent.
  - bit_cnt is cleared.
  - sdo is driven 0.
- CMD: eight rising edges shift in the command byte.
  - bit7 = R/W (1 = read), bit6 = MB (multi-byte), bits5:0 = address.
  - On the 8th edge the FSM moves to DATA. For a read, the out-shift register is loaded with reg[addr], and bit7 appears on the next falling edge.
- DATA, byte boundary: every 8 rising edges completes a byte.
  - Write: commit the byte if the address is writable, then pulse wr_strobe and update wr_addr/wr_data.
  - If MB=1: address increments, wrapping 0x3F to 0x00, and the read register is reloaded.
  - If MB=0: only the first data byte is acted on. Later bytes read 0x00 and writes to them are ignored.
- Register map:
  - 0x00 = DEVID.
  - 0x2D and 0x31 are read/write.
  - 0x30 = INT_SOURCE (see option).
  - 0x32..0x37 = shadow x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8].
  - All other addresses read 0x00 and ignore writes. A write to a read-only address produces no wr_strobe.
- cs_n rising in any state returns the FSM to IDLE and drives sdo_oe=0, sdo=0.
  - A partial data byte is discarded and never committed.
  - txn_done pulses only if the command byte had completed.
- sclk edges while cs_n is high are ignored.
- Reset asserted mid-transaction returns the block to reset values immediately. The transaction is not resumed after reset releases; the next cs_n fall starts a fresh one.
- If sample_valid arrives during a transaction, the shadow registers are not updated. The new sample is taken at the next cs_n fall.

Optional Feature:
RESPONDER_DATA_READY_EN
- Defined:
  - A sample_valid pulse sets a pending DATA_READY flag, which is visible as bit7 of 0x30.
  - int1 is high while the flag is set.
  - The flag clears when a read transaction's byte from address 0x32 completes.
  - If sample_valid and that clear occur in the same cycle, set wins.
- Not defined: 0x30 reads 0x00, int1 is tied 0, and the flag logic is absent.

Test Plan:
- Read DEVID: command 0x80, then one dummy byte -> sdo returns 0xE5; txn_done pulses once after cs_n rises.
- Write POWER_CTL: command 0x2D with data 0x08 -> power_ctl=0x08 and measure=1; one wr_strobe pulse with wr_addr=0x2D and wr_data=0x08.
- Burst read: with x=0x1234, y=0xABCD, z=0x00FF, command 0xF2 followed by 6 bytes -> sdo returns 34 12 CD AB FF 00.
- Snapshot and abort:
  - Change x_in to 0x5678 after the command byte -> the burst still returns 34 12.
  - Separately, write 0x31 and raise cs_n after 4 data bits -> data_format stays 0x00 and no wr_strobe.
- Wrap and read-only:
  - Command 0xFF followed by 2 bytes -> returns 0x00 then 0xE5.
  - Write 0x55 to 0x00 -> DEVID unchanged and no wr_strobe.
- With RESPONDER_DATA_READY_EN defined:
  - Pulse sample_valid -> int1=1 and 0x30 reads 0x80.
  - A burst read from 0x32 -> int1=0.
  - Assert rst mid-burst -> all outputs 0 on the same clock.
